rx_data_sampler: RTL and testbench

UART Rx stage directly downstream of the start-bit detector. It consumes the synchronised serial line and the start_detected level, then runs the frame FSM: START, DATA_0..DATA_n, PARITY, STOP. It samples each bit at mid-bit, assembles the byte LSB-first, and checks even parity and the stop bit. It presents one data_valid pulse per frame and exports its state encoding to the detector's formal checks.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/rx_data_sampler_if.sv | 26 ++
 rtl/rx_bit_timer.sv | 29 ++
 rtl/rx_data_sampler.sv | 144 ++++++++++++++
 tb/tb_rx_data_sampler.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART Rx definitions: frame state codes and widths used by the start detector and the data sampler.
// Codes depending on data width are exposed as functions so each importer can size them from its own parameter.
package uart_rx_pkg;

    localparam int Rx_IDLE            = 0;
    localparam int Rx_START_BIT       = 1;
    localparam int Rx_DATA_BIT_0      = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int NUMBER_OF_BITS     = DEFAULT_DATA_WIDTH + 3;

    function automatic int rx_parity_state(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int rx_stop_state(input int data_width);
        return data_width + 3;
    endfunction

    function automatic int rx_state_width(input int data_width);
        return $clog2(data_width + 4);
    endfunction

endpackage

// File: rtl/rx_data_sampler_if.sv
// Serial line in / assembled frame out between the Rx front end and the data sampler.
// master drives the line and start level; slave (the sampler) drives the frame results and its state.
interface rx_data_sampler_if #(
    parameter int INPUT_DATA_WIDTH = 8
);
    localparam int STATE_WIDTH = uart_rx_pkg::rx_state_width(INPUT_DATA_WIDTH);

    logic                        serial_in_synced;
    logic                        start_detected;
    logic [INPUT_DATA_WIDTH-1:0] received_data;
    logic                        data_valid;
    logic                        parity_error;
    logic                        framing_error;
    logic [STATE_WIDTH-1:0]      state;

    modport master (
        output serial_in_synced, start_detected,
        input  received_data, data_valid, parity_error, framing_error, state
    );

    modport slave (
        input  serial_in_synced, start_detected,
        output received_data, data_valid, parity_error, framing_error, state
    );

endinterface

// File: rtl/rx_bit_timer.sv
// Per-bit clock counter; sample_tick pulses at mid start bit (half_sel) or at the end of a full bit period.
// Counter restarts from 0 whenever clear is high; no backpressure.
module rx_bit_timer #(
    parameter int CLOCKS_PER_BIT = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic half_sel,
    output logic sample_tick
);
    localparam int CW   = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign sample_tick = half_sel ? (count == HALF_LAST) : (count == FULL_LAST);

endmodule

// File: rtl/rx_data_sampler.sv
// UART Rx frame FSM: samples start/data/parity/stop at bit centres, assembles LSB-first, flags parity/framing errors.
// data_valid pulses HALF + (W + P + 1) * CLOCKS_PER_BIT + 1 cycles after the start edge; no backpressure.
module rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int CLOCKS_PER_BIT   = 5000
) (
    input  logic               clk,
    input  logic               reset,
    rx_data_sampler_if.slave   bus
);
    localparam int SW = rx_state_width(INPUT_DATA_WIDTH);

    typedef enum logic [SW-1:0] {
        S_IDLE   = SW'(Rx_IDLE),
        S_START  = SW'(Rx_START_BIT),
        S_DATA0  = SW'(Rx_DATA_BIT_0),
        S_PARITY = SW'(rx_parity_state(INPUT_DATA_WIDTH)),
        S_STOP   = SW'(rx_stop_state(INPUT_DATA_WIDTH))
    } rx_state_t;

    localparam rx_state_t S_LAST_DATA = rx_state_t'(SW'(Rx_DATA_BIT_0 + INPUT_DATA_WIDTH - 1));

    rx_state_t                   state, state_nxt;
    logic                        start_q;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg;
    logic                        parity_bad;
    logic [INPUT_DATA_WIDTH-1:0] received_data;
    logic                        data_valid, parity_error, framing_error;
    logic                        half_sel, sample_tick, timer_clear;
    logic                        frame_start, capture_data, capture_parity, finish;
    logic                        line;

    assign line = bus.serial_in_synced;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        half_sel       = 1'b0;
        frame_start    = 1'b0;
        capture_data   = 1'b0;
        capture_parity = 1'b0;
        finish         = 1'b0;
        if (state == S_IDLE) begin
            if (bus.start_detected && !start_q) begin
                state_nxt   = S_START;
                frame_start = 1'b1;
            end
        end else if (state == S_START) begin
            half_sel = 1'b1;
            if (sample_tick) begin
                state_nxt = line ? S_IDLE : S_DATA0;
            end
        end else if (state >= S_DATA0 && state <= S_LAST_DATA) begin
            if (sample_tick) begin
                capture_data = 1'b1;
                if (state != S_LAST_DATA) begin
                    state_nxt = rx_state_t'(state + SW'(1));
                end else if (PARITY_ENABLED != 0) begin
                    state_nxt = S_PARITY;
                end else begin
                    state_nxt = S_STOP;
                end
            end
        end else if (PARITY_ENABLED != 0 && state == S_PARITY) begin
            if (sample_tick) begin
                capture_parity = 1'b1;
                state_nxt      = S_STOP;
            end
        end else if (state == S_STOP) begin
            if (sample_tick) begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
        end else begin
            state_nxt = S_IDLE;
        end
    end

    // Counter restarts on every state change and stays parked while idle.
    assign timer_clear = (state_nxt != state) || (state == S_IDLE);

    rx_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (timer_clear),
        .half_sel    (half_sel),
        .sample_tick (sample_tick)
    );

    // start_q resets high so a start level held through reset is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q       <= 1'b1;
            shift_reg     <= '0;
            parity_bad    <= 1'b0;
            received_data <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            start_q    <= bus.start_detected;
            data_valid <= finish;
            if (frame_start) begin
                shift_reg  <= '0;
                parity_bad <= 1'b0;
            end
            if (capture_data) begin
                for (int k = 0; k < INPUT_DATA_WIDTH; k++) begin
                    if (state == rx_state_t'(SW'(Rx_DATA_BIT_0 + k))) begin
                        shift_reg[k] <= line;
                    end
                end
            end
            if (capture_parity) begin
                parity_bad <= line ^ (^shift_reg);
            end
            if (finish) begin
                received_data <= shift_reg;
                parity_error  <= (PARITY_ENABLED != 0) && parity_bad;
                framing_error <= ~line;
            end
        end
    end

    assign bus.state         = state;
    assign bus.received_data = received_data;
    assign bus.data_valid    = data_valid;
    assign bus.parity_error  = parity_error;
    assign bus.framing_error = framing_error;

    assert property (@(posedge clk) disable iff (reset) state <= S_STOP);
    assert property (@(posedge clk) disable iff (reset) data_valid |=> !data_valid);

endmodule

// File: tb/tb_rx_data_sampler.sv
// Drives UART frames into a parity and a no-parity sampler and checks them against a bit-list frame model.
module tb_rx_data_sampler;
    localparam int W    = 8;
    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_data_sampler_if #(.INPUT_DATA_WIDTH(W)) bus_p ();
    rx_data_sampler_if #(.INPUT_DATA_WIDTH(W)) bus_n ();

    rx_data_sampler #(.INPUT_DATA_WIDTH(W), .PARITY_ENABLED(1), .CLOCKS_PER_BIT(CPB)) dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_p.slave)
    );

    rx_data_sampler #(.INPUT_DATA_WIDTH(W), .PARITY_ENABLED(0), .CLOCKS_PER_BIT(CPB)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_p = '0;
    logic [W-1:0] prev_n = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Parity bit value that makes the total number of ones even.
    function automatic logic even_par(input logic [W-1:0] d);
        int ones = 0;
        for (int k = 0; k < W; k++) ones += int'(d[k]);
        return (ones % 2) == 1;
    endfunction

    task automatic run_frame(input bit np, input logic [W-1:0] data, input logic par_bit,
                             input logic stop_bit, input bit false_start, input int reset_at,
                             input int last_cycle);
        logic q[$];
        int   lat, last;
        bit   completes;
        logic exp_pe, exp_fe, line, dv;
        logic [3:0] st;
        logic [W-1:0] rd, prev;

        q.push_back(1'b0);
        for (int k = 0; k < W; k++) q.push_back(data[k]);
        if (!np) q.push_back(par_bit);
        q.push_back(stop_bit);
        lat       = HALF + (W + (np ? 0 : 1) + 1) * CPB + 1;
        last      = (last_cycle < 0) ? lat + 2 : last_cycle;
        completes = !false_start && reset_at < 0;
        exp_pe    = np ? 1'b0 : (par_bit != even_par(data));
        exp_fe    = !stop_bit;
        prev      = np ? prev_n : prev_p;

        for (int c = 0; c <= last; c++) begin
            tick();
            if (false_start) line = (c < 2) ? 1'b0 : 1'b1;
            else             line = (c / CPB < q.size()) ? q[c / CPB] : 1'b1;
            bus_p.serial_in_synced = line;
            bus_n.serial_in_synced = line;
            bus_p.start_detected   = !np && c < 3;
            bus_n.start_detected   = np && c < 3;
            reset                  = (c == reset_at);

            dv = np ? bus_n.data_valid    : bus_p.data_valid;
            st = np ? bus_n.state         : bus_p.state;
            rd = np ? bus_n.received_data : bus_p.received_data;

            check("data_valid", dv, completes && c == lat);
            if (c == 1) check("state_start", st, 1);
            if (completes && c == HALF + 1) check("state_data0", st, 2);
            if (completes && c == lat) begin
                check("received_data", rd, data);
                check("parity_error", np ? bus_n.parity_error : bus_p.parity_error, exp_pe);
                check("framing_error", np ? bus_n.framing_error : bus_p.framing_error, exp_fe);
                if (np) prev_n = data; else prev_p = data;
            end
            if (completes && c == lat + 1) check("state_idle_after", st, 0);
            if (false_start && c == HALF + 1) begin
                check("false_start_state", st, 0);
                check("false_start_data", rd, prev);
            end
            if (reset_at >= 0 && c == reset_at + 1) begin
                check("rst_state", st, 0);
                check("rst_data", rd, 0);
                check("rst_valid", dv, 0);
                check("rst_perr", bus_p.parity_error, 0);
                check("rst_ferr", bus_p.framing_error, 0);
                prev_p = '0;
                prev_n = '0;
            end
            if (np) check("np_state_not_10", st == 4'd10, 0);
        end
        reset                  = 1'b0;
        bus_p.start_detected   = 1'b0;
        bus_n.start_detected   = 1'b0;
        bus_p.serial_in_synced = 1'b1;
        bus_n.serial_in_synced = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        bit np;
        logic [W-1:0] d;
        logic pb, sb;

        reset                  = 1'b1;
        bus_p.serial_in_synced = 1'b1;
        bus_n.serial_in_synced = 1'b1;
        bus_p.start_detected   = 1'b1;
        bus_n.start_detected   = 1'b1;
        tick();
        tick();
        check("reset_state", bus_p.state, 0);
        check("reset_valid", bus_p.data_valid, 0);
        check("reset_data", bus_p.received_data, 0);
        check("reset_perr", bus_p.parity_error, 0);
        check("reset_ferr", bus_p.framing_error, 0);
        check("reset_state_np", bus_n.state, 0);

        // start level held high across reset release must not open a frame
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held_start_idle", bus_p.state, 0);
            check("held_start_idle_np", bus_n.state, 0);
        end
        bus_p.start_detected = 1'b0;
        bus_n.start_detected = 1'b0;
        tick();
        tick();

        run_frame(0, 8'hA5, 1'b0, 1'b1, 0, -1, 90);
        run_frame(0, 8'h00, 1'b0, 1'b1, 1, -1, 20);
        run_frame(0, 8'hA5, 1'b1, 1'b1, 0, -1, -1);
        run_frame(0, 8'h3C, even_par(8'h3C), 1'b1, 0, -1, -1);
        run_frame(0, 8'h00, 1'b0, 1'b0, 0, -1, -1);
        run_frame(0, 8'hFF, 1'b0, 1'b1, 0, 40, 100);
        run_frame(1, 8'h81, 1'b0, 1'b1, 0, -1, 82);

        for (int i = 0; i < 8; i++) begin
            np = ($urandom_range(0, 1) == 1);
            d  = W'($urandom_range(0, 255));
            pb = even_par(d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) != 0);
            run_frame(np, d, pb, sb, 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
